// File: rtl/i2c_byte_tx_if.sv
// Bus/handshake bundle for i2c_byte_tx: SCL/SDA samples, tx byte handshake, pad enables, ack report.
// master = block feeding bytes and bus samples; slave = the byte transmitter.
interface i2c_byte_tx_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       scl_edge;
    logic             sda_in;
    logic             abort;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             sda_oe;
    logic             scl_oe;
    logic             ack_valid;
    logic             ack_nack;
    logic             busy;

    modport master (
        output scl_edge, sda_in, abort, tx_data, tx_valid,
        input  tx_ready, sda_oe, scl_oe, ack_valid, ack_nack, busy
    );

    modport slave (
        input  scl_edge, sda_in, abort, tx_data, tx_valid,
        output tx_ready, sda_oe, scl_oe, ack_valid, ack_nack, busy
    );
endinterface

// File: rtl/i2c_byte_tx.sv
// I2C slave-side byte transmitter, MSB first; open-drain SDA, optional SCL stretch (I2C_TX_CLOCK_STRETCH_EN).
// Latency: sda_oe/scl_oe/ack_valid change the cycle after the qualifying scl_edge sample.
// Backpressure: tx_ready only in IDLE; tx_valid elsewhere is ignored. abort/rst force IDLE.
module i2c_byte_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    i2c_byte_tx_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        WAITLOW,
        SHIFT_RISE,
        SHIFT_FALL,
        ACK_RISE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CNT_W-1:0] cnt;
    logic             sda_oe_q;
    logic             ack_valid_q;
    logic             ack_nack_q;

    assign shreg_nxt = shreg << 1;

`ifdef I2C_TX_CLOCK_STRETCH_EN
    logic scl_oe_q;
    logic stretch;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            sda_oe_q    <= 1'b0;
            ack_valid_q <= 1'b0;
            ack_nack_q  <= 1'b0;
`ifdef I2C_TX_CLOCK_STRETCH_EN
            scl_oe_q    <= 1'b0;
            stretch     <= 1'b0;
`endif
        end else begin
            ack_valid_q <= 1'b0;
            if (bus.abort) begin
                state    <= IDLE;
                sda_oe_q <= 1'b0;
`ifdef I2C_TX_CLOCK_STRETCH_EN
                scl_oe_q <= 1'b0;
                stretch  <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        sda_oe_q <= 1'b0;
                        if (bus.tx_valid) begin
                            shreg <= bus.tx_data;
                            cnt   <= '0;
                            state <= WAITLOW;
                        end
`ifdef I2C_TX_CLOCK_STRETCH_EN
                        // Hold SCL low after an ACKed byte until the next one arrives
                        else if (stretch && !bus.scl_edge[0]) begin
                            scl_oe_q <= 1'b1;
                        end
`endif
                    end
                    WAITLOW: begin
                        if (!bus.scl_edge[0]) begin
                            sda_oe_q <= ~shreg[WIDTH-1];
                            state    <= SHIFT_RISE;
                        end
                    end
                    SHIFT_RISE: begin
`ifdef I2C_TX_CLOCK_STRETCH_EN
                        scl_oe_q <= 1'b0;
`endif
                        if (bus.scl_edge == 2'b01) begin
                            cnt   <= cnt + 1'b1;
                            state <= SHIFT_FALL;
                        end
                    end
                    SHIFT_FALL: begin
                        if (bus.scl_edge == 2'b10) begin
                            if (cnt < LAST_BIT) begin
                                shreg    <= shreg_nxt;
                                sda_oe_q <= ~shreg_nxt[WIDTH-1];
                                state    <= SHIFT_RISE;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state    <= ACK_RISE;
                            end
                        end
                    end
                    ACK_RISE: begin
                        if (bus.scl_edge == 2'b01) begin
                            ack_nack_q  <= bus.sda_in;
                            ack_valid_q <= 1'b1;
                            state       <= IDLE;
`ifdef I2C_TX_CLOCK_STRETCH_EN
                            stretch     <= ~bus.sda_in;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.tx_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.sda_oe    = sda_oe_q;
    assign bus.ack_valid = ack_valid_q;
    assign bus.ack_nack  = ack_nack_q;
`ifdef I2C_TX_CLOCK_STRETCH_EN
    assign bus.scl_oe    = scl_oe_q;
`else
    assign bus.scl_oe    = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_byte_tx.sv
// Directed bench for i2c_byte_tx: table of bytes with expected SDA drive pattern and ack result,
// plus hand sequences for SCL-high accept, abort, mid-transfer reset and clock stretch.
module tb_i2c_byte_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_lvl = 1'b0;
    int   checks = 0;
    int   errors = 0;

`ifdef I2C_TX_CLOCK_STRETCH_EN
    localparam logic STRETCH = 1'b1;
`else
    localparam logic STRETCH = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       ack_sda;
        logic [7:0] exp_oe;
        logic       exp_nack;
        bit         glitch;
    } vec_t;

    vec_t vecs[4];

    i2c_byte_tx_if #(.WIDTH(8)) bus ();

    i2c_byte_tx #(.WIDTH(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One SCL transition: edge sample for one cycle, then a steady sample.
    task automatic scl_to(input logic v);
        bus.scl_edge = {scl_lvl, v};
        tick();
        scl_lvl = v;
        bus.scl_edge = {v, v};
        tick();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bus.tx_data  = v.data;
        bus.tx_valid = 1'b1;
        tick();
        chk({tag, " busy after accept"}, 8'(bus.busy), 8'd1);
        chk({tag, " tx_ready low"}, 8'(bus.tx_ready), 8'd0);
        bus.tx_valid = 1'b0;
        bus.scl_edge = {scl_lvl, scl_lvl};
        tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s bit%0d sda_oe", tag, i), 8'(bus.sda_oe), 8'(v.exp_oe[7-i]));
            scl_to(1'b1);
            if (v.glitch && i == 3) begin
                bus.scl_edge = 2'b01;
                tick();
                bus.scl_edge = 2'b11;
                tick();
            end
            scl_to(1'b0);
        end
        chk({tag, " release for ack"}, 8'(bus.sda_oe), 8'd0);
        chk({tag, " busy before ack"}, 8'(bus.busy), 8'd1);
        chk({tag, " no early ack_valid"}, 8'(bus.ack_valid), 8'd0);
        bus.sda_in   = v.ack_sda;
        bus.scl_edge = 2'b01;
        tick();
        chk({tag, " ack_valid pulse"}, 8'(bus.ack_valid), 8'd1);
        chk({tag, " ack_nack"}, 8'(bus.ack_nack), 8'(v.exp_nack));
        chk({tag, " idle after ack"}, 8'(bus.busy), 8'd0);
        chk({tag, " tx_ready after ack"}, 8'(bus.tx_ready), 8'd1);
        scl_lvl      = 1'b1;
        bus.scl_edge = 2'b11;
        tick();
        chk({tag, " ack_valid one cycle"}, 8'(bus.ack_valid), 8'd0);
        chk({tag, " ack_nack held"}, 8'(bus.ack_nack), 8'(v.exp_nack));
        bus.sda_in = 1'b1;
        scl_to(1'b0);
    endtask

    task automatic accept_high(input logic [7:0] d, input logic exp_oe_fall, input string tag);
        scl_to(1'b1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("%s no drive while high %0d", tag, i), 8'(bus.sda_oe), 8'd0);
        end
        scl_to(1'b0);
        chk({tag, " drive after fall"}, 8'(bus.sda_oe), 8'(exp_oe_fall));
        chk({tag, " busy"}, 8'(bus.busy), 8'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic abort_after(input logic [7:0] d, input int nrise, input logic exp_oe, input string tag);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        tick();
        for (int r = 0; r < nrise; r++) begin
            scl_to(1'b1);
            if (r < nrise - 1) scl_to(1'b0);
        end
        chk({tag, " sda_oe before abort"}, 8'(bus.sda_oe), 8'(exp_oe));
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk({tag, " sda_oe after abort"}, 8'(bus.sda_oe), 8'd0);
        chk({tag, " busy after abort"}, 8'(bus.busy), 8'd0);
        chk({tag, " tx_ready after abort"}, 8'(bus.tx_ready), 8'd1);
        chk({tag, " no ack_valid"}, 8'(bus.ack_valid), 8'd0);
        scl_to(1'b0);
        scl_to(1'b1);
        chk({tag, " still idle"}, 8'(bus.busy), 8'd0);
        chk({tag, " still no ack_valid"}, 8'(bus.ack_valid), 8'd0);
        scl_to(1'b0);
    endtask

    initial begin
        bus.scl_edge = 2'b00;
        bus.sda_in   = 1'b1;
        bus.abort    = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;

        //            data   ack_sda exp_oe  nack glitch
        vecs[0] = '{8'hA5, 1'b0, 8'h5A, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'hC3, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[3] = '{8'h81, 1'b0, 8'h7E, 1'b0, 1'b1};

        tick();
        tick();
        chk("rst tx_ready", 8'(bus.tx_ready), 8'd1);
        chk("rst sda_oe", 8'(bus.sda_oe), 8'd0);
        chk("rst scl_oe", 8'(bus.scl_oe), 8'd0);
        chk("rst ack_valid", 8'(bus.ack_valid), 8'd0);
        chk("rst ack_nack", 8'(bus.ack_nack), 8'd0);
        chk("rst busy", 8'(bus.busy), 8'd0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 4; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        accept_high(8'hFF, 1'b0, "ff_high");
        accept_high(8'h00, 1'b1, "00_high");

        abort_after(8'h3C, 3, 1'b0, "abort_3c");
        abort_after(8'h00, 2, 1'b1, "abort_00");

        // Reset in the middle of a byte releases SDA next cycle
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        tick();
        chk("midrst sda driven", 8'(bus.sda_oe), 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst sda_oe", 8'(bus.sda_oe), 8'd0);
        chk("midrst busy", 8'(bus.busy), 8'd0);
        chk("midrst ack_valid", 8'(bus.ack_valid), 8'd0);
        chk("midrst scl_oe", 8'(bus.scl_oe), 8'd0);
        tick();

        // Clock stretch after an ACKed byte (constant 0 when the feature is compiled out)
        run_vec(vecs[0], "stretch_pre");
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("stretch hold %0d", c), 8'(bus.scl_oe), 8'(STRETCH));
            tick();
        end
        bus.tx_data  = 8'h0F;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        chk("stretch at accept", 8'(bus.scl_oe), 8'(STRETCH));
        tick();
        chk("stretch msb driven", 8'(bus.sda_oe), 8'd1);
        chk("stretch still held", 8'(bus.scl_oe), 8'(STRETCH));
        tick();
        chk("stretch released", 8'(bus.scl_oe), 8'd0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("final idle", 8'(bus.busy), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_byte_tx.md
I2C_BYTE_TX -- requirements
Module: i2c_byte_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of data bits per transfer (MSB first).
REQ-002 SHALL have parameter CNT_W, default 4, bit-counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port scl_edge  input  2  synchronized SCL history {previous,current}: 2'b01 rise, 2'b10 fall, 2'b00 low, 2'b11 high.
REQ-006 SHALL have port sda_in  input  1  synchronized SDA level.
REQ-007 SHALL have port abort  input  1  one-cycle pulse on bus START/STOP detection.
REQ-008 SHALL have port tx_data  input  WIDTH  byte to transmit.
REQ-009 SHALL have port tx_valid  input  1  tx_data valid.
REQ-010 SHALL have port tx_ready  output  1  block accepts tx_data this cycle.
REQ-011 SHALL have port sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-012 SHALL have port scl_oe  output  1  1 = hold SCL low (clock stretch).
REQ-013 SHALL have port ack_valid  output  1  one-cycle pulse, ack_nack valid.
REQ-014 SHALL have port ack_nack  output  1  1 = master NACK, 0 = master ACK.
REQ-015 SHALL have port busy  output  1  transfer in progress (state != IDLE).

Function
REQ-016 SHALL implement states IDLE, WAITLOW, SHIFT_RISE, SHIFT_FALL, ACK_RISE.
REQ-017 IDLE: tx_ready=1; tx_valid&tx_ready captures tx_data into shift register, clears bit counter, enters WAITLOW.
REQ-018 WAITLOW: sda_oe=0; on scl_edge[0]==0 (SCL low or falling) SHALL drive MSB (sda_oe = ~bit) and enter SHIFT_RISE; never drive SDA while SCL high.
REQ-019 SHIFT_RISE: on 2'b01 SHALL increment bit counter and enter SHIFT_FALL; repeated 2'b01/2'b11 without intervening fall SHALL NOT increment again.
REQ-020 SHIFT_FALL: on 2'b10 with counter < WIDTH SHALL shift left, drive next bit same cycle, return to SHIFT_RISE.
REQ-021 SHIFT_FALL: on 2'b10 with counter == WIDTH SHALL release SDA (sda_oe=0) and enter ACK_RISE.
REQ-022 ACK_RISE: on 2'b01 SHALL register ack_nack = sda_in, pulse ack_valid for exactly one cycle, return to IDLE.
REQ-023 Latency: sda_oe SHALL update in the cycle after the qualifying scl_edge sample.
REQ-024 tx_ready SHALL be 0 in every state except IDLE; tx_valid outside IDLE SHALL be ignored.
REQ-025 abort SHALL have priority over every other event: next cycle state=IDLE, sda_oe=0, scl_oe=0, no ack_valid pulse.
REQ-026 Counter arithmetic SHALL be CNT_W bits, never wrap within a byte; counter resets on every accept.
REQ-027 ack_nack SHALL hold its value until the next ack_valid or reset.

Reset
REQ-028 With rst=1 at posedge clk: state=IDLE, tx_ready=1, sda_oe=0, scl_oe=0, ack_valid=0, ack_nack=0, busy=0, shift register=0, counter=0, stretch flag=0.
REQ-029 Reset mid-transfer SHALL release SDA and SCL in the following cycle; no ack_valid pulse.

Configuration
REQ-030 Macro I2C_TX_CLOCK_STRETCH_EN SHALL control clock stretching.
REQ-031 Defined: a stretch flag set on ACK (ack_nack=0), cleared on NACK, abort, rst; in IDLE with flag set and scl_edge==2'b10/2'b00 and no tx_valid, scl_oe=1 until a byte is accepted; scl_oe SHALL drop one cycle after MSB is driven.
REQ-032 Undefined: scl_oe SHALL be constant 0; flag logic absent; all other behaviour identical.

Verification
REQ-033 Send 8'hA5, SCL toggling, master ACK -> sda_oe sequence 0,1,0,1,1,0,1,0 (bit 1=release), then release, ack_valid pulse, ack_nack=0.
REQ-034 Send 8'h00, master NACK (sda_in=1 at 9th rise) -> SDA held low 8 bits, ack_nack=1, back to IDLE, tx_ready=1.
REQ-035 Accept 8'hFF while SCL high -> sda_oe stays 0 until first 2'b10, no drive during high.
REQ-036 abort pulse after 3rd rise of 8'h3C -> next cycle sda_oe=0, busy=0, no ack_valid.
REQ-037 Glitch: two 2'b01 samples without fall during 8'h81 -> counter advances once, byte still completes after 8 falls.
REQ-038 With I2C_TX_CLOCK_STRETCH_EN, ACK then fall with tx_valid low for 20 cycles -> scl_oe=1 for those cycles, drops one cycle after next MSB driven.
